clock_monitor: RTL and testbench
================================

# clock_monitor

Measures the period and high time of a divided clock, counted in cycles of the fast source clock that produced it. Sits directly downstream of the frequency dividers and consumes their `clock_out` as an ordinary sampled data input. It does not use that signal as a clock. It reports each complete period with a one-cycle valid strobe, and raises sticky error flags for wrong-period and stuck-clock conditions. Used on-chip and in benches to qualify divider outputs.

## Interface
- `CNT_W`, default 8: width of the period and high-time counters and outputs.
- `EXP_PERIOD`, default 3: expected period in `clock_in` cycles, compared on every measurement.
- `clock_in`, input, 1 bit: source clock. All logic is on its rising edge.
- `reset_n`, input, 1 bit: asynchronous active-low reset.
- `clock_mon`, input, 1 bit: divided clock under test, sampled as data.
- `clr_flags`, input, 1 bit: synchronous clear of `period_err` and `timeout`.
- `period`, output, `CNT_W` bits: last measured period in `clock_in` cycles.
- `high_time`, output, `CNT_W` bits: `clock_in` cycles `clock_mon` was sampled high in that period.
- `meas_valid`, output, 1 bit: one-cycle pulse when `period` and `high_time` update.
- `period_err`, output, 1 bit: sticky; set when a measured period is not equal to `EXP_PERIOD`.
- `timeout`, output, 1 bit: sticky; set when no rising edge arrives within 2^CNT_W−1 cycles.

## Operation
- Sample path: `s1` is the registered `clock_mon`. `s2` is the registered `s1`. `rise = s1 & ~s2`.
- FSM states:
  - ARM: waiting for the first edge. Reset state, also entered after a timeout.
  - RUN: measuring.
- ARM + `rise`: `cnt <= 1`, `hcnt <= 1`, go to RUN. No `meas_valid`.
- RUN, no `rise`: `cnt <= cnt + 1`, `hcnt <= hcnt + s1`.
- RUN + `rise`: `period <= cnt`, `high_time <= hcnt`, `meas_valid <= 1`, `cnt <= 1`, `hcnt <= 1`, stay in RUN.
- Timeout: RUN, no `rise`, and `cnt == 2^CNT_W−1` → `timeout <= 1`, go to ARM. Counters hold. No valid.
- Period error: `period_err <= 1` in the cycle `meas_valid` is set, if the new period is not equal to `EXP_PERIOD`.
- Flag clear: `clr_flags` clears both sticky flags. If a set and a clear happen in the same cycle, the set wins.
- Counters never wrap. Saturation is reached only through the timeout path.
- Mid-operation reset: everything returns immediately to reset values and ARM. The first edge after release only arms the block.

## Timing
- Reset values: `period`=0, `high_time`=0, `meas_valid`=0, `period_err`=0, `timeout`=0. Internal state: `s1`=`s2`=0, `cnt`=`hcnt`=0, ARM.
- Edge detection latency: a `clock_mon` rising edge sampled at clock `t` gives `rise` in cycle `t+1` (without the sync option).
- Output latency: `meas_valid`, `period`, `high_time` and `period_err` become visible in the cycle after `rise`.
- Period convention: consecutive rises N cycles apart report `period` = N.
- First measurement: the first `meas_valid` follows the second detected rising edge after reset or timeout.
- Steady state: exactly one `meas_valid` per monitored period. Outputs hold between pulses.
- `clock_mon` held at 1 from reset produces one rise, then a timeout; it never produces a valid.

## Configuration
- `CLOCK_MONITOR_SYNC_EN` defined: two extra flops (a synchronizer) are inserted ahead of `s1`. This supports a `clock_mon` that is asynchronous to `clock_in`. All latencies from `clock_mon` grow by 2 cycles. Measured values are unchanged in steady state.
- Undefined: `clock_mon` is assumed synchronous to `clock_in` (it comes from the divider on the same clock). `s1` samples it directly.

## Structure
- Shared package holds:
  - the FSM state typedef (`ARM`, `RUN`);
  - the saturation constant, derived from `CNT_W`;
  - the default `EXP_PERIOD`.
- One sub-module, `edge_detect`:
  - optional synchronizer, `s1`/`s2` and the `rise` output;
  - reused by other monitors in the codebase.
- The counters, FSM and flags remain in `clock_monitor`.

## Test plan
- ÷3 stimulus: `clock_mon` repeats high 1 / low 2 cycles after release → first valid after the second rise, then every 3 cycles: `period`=3, `high_time`=1, `period_err`=0.
- ÷3 with 2/1 duty: high 2 / low 1 → `period`=3, `high_time`=2, flags stay 0.
- Wrong divide ratio: ÷4 stimulus, high 2 / low 2 → `period`=4, `high_time`=2, `period_err`=1 on the first valid; stays set after a return to ÷3 until `clr_flags`.
- Stuck clock: `clock_mon` held low after running → `timeout`=1 exactly 255 cycles after the last rise (CNT_W=8), no further valid. Re-arms on the next rise; next valid only after a second rise.
- Simultaneous set and clear: `clr_flags` asserted in the cycle a ÷4 period is reported → `period_err`=1. A later `clr_flags` in a cycle with no error clears it to 0.
- Mid-run reset: `reset_n` pulsed low mid-period → all outputs 0 within the reset. The first rise after release gives no valid; the second does, with correct values.

Source files
------------

// File: rtl/clock_monitor_pkg.sv
// Shared definitions for clock_monitor and related monitors.
//   - mon_state_e : measurement FSM states (ARM, RUN)
//   - CNT_W_DEF, EXP_PERIOD_DEF : default counter width and expected period
//   - sat_count() : terminal value of a CNT_W-bit period counter
package clock_monitor_pkg;

  typedef enum logic {
    ARM = 1'b0,
    RUN = 1'b1
  } mon_state_e;

  localparam int CNT_W_DEF      = 8;
  localparam int EXP_PERIOD_DEF = 3;

  // All-ones value of a cnt_w-bit counter; the period counter times out here
  // rather than wrapping.
  function automatic int sat_count(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  localparam int CNT_SAT_DEF = sat_count(CNT_W_DEF);

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a slow signal sampled as data on clock_in.
// Optional build macro: CLOCK_MONITOR_SYNC_EN inserts a two-flop
// synchronizer ahead of s1 for inputs asynchronous to clock_in
// (adds two cycles of latency).
// Ports:
//   clock_in : sampling clock (rising edge)
//   reset_n  : asynchronous active-low reset
//   sig_in   : signal under observation
//   s1       : registered (optionally synchronized) copy of sig_in
//   rise     : s1 & ~s2, high for one cycle per rising edge of sig_in
module edge_detect (
  input  logic clock_in,
  input  logic reset_n,
  input  logic sig_in,
  output logic s1,
  output logic rise
);

  logic samp;
  logic s1_q, s1_d;
  logic s2_q, s2_d;

`ifdef CLOCK_MONITOR_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], sig_in};

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign samp = sync_q[1];
`else
  assign samp = sig_in;
`endif

  always_comb begin
    s1_d = samp;
    s2_d = s1_q;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s1   = s1_q;
  assign rise = s1_q & ~s2_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures period and high time of a divided clock (clock_mon), counted in
// clock_in cycles. clock_mon is sampled as data, never used as a clock.
// Optional build macro: CLOCK_MONITOR_SYNC_EN (synchronizer in edge_detect).
//
// state | meaning
// ------+------------------------------------------------------------
// ARM   | waiting for first rising edge (after reset or timeout)
// RUN   | counting; each rising edge closes one period measurement
//
// Ports:
//   clock_in   : source clock, all logic on its rising edge
//   reset_n    : asynchronous active-low reset
//   clock_mon  : divided clock under test
//   clr_flags  : synchronous clear of period_err and timeout
//   period     : last measured period (clock_in cycles)
//   high_time  : cycles clock_mon was high in that period
//   meas_valid : one-cycle pulse when period/high_time update
//   period_err : sticky, a period differed from EXP_PERIOD
//   timeout    : sticky, no rising edge within the counter range
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_PERIOD = EXP_PERIOD_DEF
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             clock_mon,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             period_err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(sat_count(CNT_W));
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s1;
  logic rise;

  edge_detect u_edge_detect (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .sig_in   (clock_mon),
    .s1       (s1),
    .rise     (rise)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
  logic             set_err;
  logic             set_tmo;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    set_err  = 1'b0;
    set_tmo  = 1'b0;

    case (state_q)
      ARM: begin
        // First edge only starts the count; no measurement yet.
        if (rise) begin
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          set_err  = (cnt_q != CNT_EXP);
          cnt_d    = CNT_ONE;
          hcnt_d   = CNT_ONE;
        end else if (cnt_q == CNT_SAT) begin
          // Counters hold at saturation; the block re-arms on the next edge.
          set_tmo = 1'b1;
          state_d = ARM;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, s1};
        end
      end
      default: state_d = ARM;
    endcase

    // A flag being set in the same cycle as a clear stays set.
    err_d = set_err | (err_q & ~clr_flags);
    tmo_d = set_tmo | (tmo_q & ~clr_flags);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARM;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign period_err = err_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor (CNT_W=8, EXP_PERIOD=3).
// Stimulus is a per-cycle table of clock_mon/clr_flags values; the expected
// outputs come from a reference model that works on sample indices:
// a period is the distance between rising-edge samples, the high time is the
// number of high samples in between.
module tb_clock_monitor;

  localparam int CNT_W = 8;
  localparam int EXP   = 3;
  localparam int SAT   = 255;
  localparam int MAXN  = 1024;
`ifdef CLOCK_MONITOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clock_in;
  logic             reset_n;
  logic             clock_mon;
  logic             clr_flags;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             period_err;
  logic             timeout;

  clock_monitor #(.CNT_W(CNT_W), .EXP_PERIOD(EXP)) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .clock_mon  (clock_mon),
    .clr_flags  (clr_flags),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .period_err (period_err),
    .timeout    (timeout)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Packed view: {valid, period[7:0], high[7:0], err, timeout}
  logic        mon_a [0:MAXN-1];
  logic        clr_a [0:MAXN-1];
  logic [18:0] exp_a [0:MAXN-1];
  logic [18:0] obs_a [0:MAXN-1];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int put(input int pos, input int reps, input int hi, input int lo);
    for (int r = 0; r < reps; r++) begin
      for (int h = 0; h < hi; h++) begin mon_a[pos] = 1'b1; clr_a[pos] = 1'b0; pos++; end
      for (int l = 0; l < lo; l++) begin mon_a[pos] = 1'b0; clr_a[pos] = 1'b0; pos++; end
    end
    return pos;
  endfunction

  // Observation i is taken after the i-th rising clock edge following reset
  // release; a rising edge in sample k shows up at observation k+1+LAT.
  function automatic void compute_model(input int n);
    int k, k0, hsum;
    bit armed, rise_ev, v, set_e, set_t, err, tmo;
    logic [7:0] per, hi;
    armed = 0; k0 = 0; err = 0; tmo = 0; per = '0; hi = '0;
    for (int i = 0; i < n; i++) begin
      k = i - 1 - LAT; v = 0; set_e = 0; set_t = 0; rise_ev = 0;
      if (k >= 0) rise_ev = mon_a[k] && (k == 0 || !mon_a[k-1]);
      if (rise_ev) begin
        if (armed) begin
          hsum = 0;
          for (int j = k0; j < k; j++) if (mon_a[j]) hsum++;
          v = 1; per = 8'(k - k0); hi = 8'(hsum);
          set_e = ((k - k0) != EXP);
        end
        armed = 1; k0 = k;
      end else if (armed && (k - k0) >= SAT) begin
        set_t = 1; armed = 0;
      end
      err = set_e | (err & !clr_a[i]);
      tmo = set_t | (tmo & !clr_a[i]);
      exp_a[i] = {v, per, hi, err, tmo};
    end
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; clock_mon = 1'b0; clr_flags = 1'b0;
    repeat (2) @(negedge clock_in);
    reset_n = 1'b1;
  endtask

  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) begin
      clock_mon = mon_a[i]; clr_flags = clr_a[i];
      @(negedge clock_in);
      obs_a[i] = {meas_valid, period, high_time, period_err, timeout};
    end
    clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0; clock_mon = 1'b0; clr_flags = 1'b0;
    repeat (3) begin @(negedge clock_in); clock_mon = ~clock_mon; end
    n_cmp++;
    if ({meas_valid, period, high_time, period_err, timeout} !== 19'd0) begin
      n_bad++; $display("FAIL reset_values: got %05h want 00000", {meas_valid, period, high_time, period_err, timeout});
    end
    @(negedge clock_in); reset_n = 1'b1;
    n = put(0, 1, 0, 6);
    run_seq(n);
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_a[i] !== 19'd0) begin n_bad++; $display("FAIL reset_idle cyc %0d: got %05h want 00000", i, obs_a[i]); end
    end
  endtask

  task automatic test_div3_h1();
    int n, fv, nv;
    do_reset();
    n = put(0, 10, 1, 2); n = put(n, 1, 0, 6);
    compute_model(n); run_seq(n);
    fv = -1; nv = 0;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL div3_h1 cyc %0d: got %05h want %05h", i, obs_a[i], exp_a[i]); end
      if (obs_a[i][18]) begin nv++; if (fv < 0) fv = i; end
    end
    n_cmp++;
    if (fv != 4 + LAT) begin n_bad++; $display("FAIL div3_h1_first_valid: got cyc %0d want %0d", fv, 4 + LAT); end
    n_cmp++;
    if (nv != 9) begin n_bad++; $display("FAIL div3_h1_valid_count: got %0d want 9", nv); end
    n_cmp++;
    if (fv >= 0 && (obs_a[fv][17:10] !== 8'd3 || obs_a[fv][9:2] !== 8'd1 || obs_a[fv][1] !== 1'b0)) begin
      n_bad++; $display("FAIL div3_h1_values: got period %0d high %0d err %0b want 3 1 0", obs_a[fv][17:10], obs_a[fv][9:2], obs_a[fv][1]);
    end
  endtask

  task automatic test_div3_h2();
    int n;
    do_reset();
    n = put(0, 10, 2, 1); n = put(n, 1, 0, 6);
    compute_model(n); run_seq(n);
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL div3_h2 cyc %0d: got %05h want %05h", i, obs_a[i], exp_a[i]); end
    end
    n_cmp++;
    if (obs_a[n-1] !== {1'b0, 8'd3, 8'd2, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL div3_h2_final: got %05h want %05h", obs_a[n-1], {1'b0, 8'd3, 8'd2, 1'b0, 1'b0});
    end
  endtask

  task automatic test_wrong_ratio();
    int n, c, fv;
    do_reset();
    n = put(0, 6, 2, 2); n = put(n, 8, 1, 2);
    c = n - 3; n = put(n, 1, 0, 6); clr_a[c] = 1'b1;
    compute_model(n); run_seq(n);
    fv = -1;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrong_ratio cyc %0d: got %05h want %05h", i, obs_a[i], exp_a[i]); end
      if (obs_a[i][18] && fv < 0) fv = i;
    end
    n_cmp++;
    if (fv < 0 || obs_a[fv][17:10] !== 8'd4 || obs_a[fv][9:2] !== 8'd2 || obs_a[fv][1] !== 1'b1) begin
      n_bad++; $display("FAIL wrong_ratio_first: got valid at %0d value %05h want period 4 high 2 err 1", fv, (fv < 0) ? 19'd0 : obs_a[fv]);
    end
    n_cmp++;
    if (obs_a[c-1][1] !== 1'b1) begin n_bad++; $display("FAIL wrong_ratio_sticky: got err %0b want 1", obs_a[c-1][1]); end
    n_cmp++;
    if (obs_a[c][1] !== 1'b0) begin n_bad++; $display("FAIL wrong_ratio_clear: got err %0b want 0", obs_a[c][1]); end
  endtask

  task automatic test_stuck_low();
    int n, ti, fv;
    do_reset();
    n = put(0, 5, 1, 2); n = put(n, 1, 0, 300); n = put(n, 4, 1, 2); n = put(n, 1, 0, 6);
    compute_model(n); run_seq(n);
    ti = -1; fv = -1;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL stuck_low cyc %0d: got %05h want %05h", i, obs_a[i], exp_a[i]); end
      if (obs_a[i][0] && ti < 0) ti = i;
      if (ti >= 0 && i > ti && obs_a[i][18] && fv < 0) fv = i;
    end
    // last rise sampled at 12; timeout 255 counts after it is acted on
    n_cmp++;
    if (ti != 12 + 256 + LAT) begin n_bad++; $display("FAIL stuck_low_timeout_cyc: got %0d want %0d", ti, 12 + 256 + LAT); end
    // re-arm at sample 315, first new valid from the rise at 318
    n_cmp++;
    if (fv != 318 + 1 + LAT) begin n_bad++; $display("FAIL stuck_low_rearm_valid: got %0d want %0d", fv, 318 + 1 + LAT); end
  endtask

  task automatic test_stuck_high();
    int n, nv;
    do_reset();
    n = put(0, 1, 300, 0);
    compute_model(n); run_seq(n);
    nv = 0;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL stuck_high cyc %0d: got %05h want %05h", i, obs_a[i], exp_a[i]); end
      if (obs_a[i][18]) nv++;
    end
    n_cmp++;
    if (nv != 0) begin n_bad++; $display("FAIL stuck_high_valids: got %0d want 0", nv); end
    n_cmp++;
    if (obs_a[256 + LAT][0] !== 1'b1 || obs_a[255 + LAT][0] !== 1'b0) begin
      n_bad++; $display("FAIL stuck_high_timeout: got %0b%0b want 01", obs_a[255 + LAT][0], obs_a[256 + LAT][0]);
    end
  endtask

  task automatic test_set_clear();
    int n, fv, c2;
    do_reset();
    n = put(0, 4, 2, 2); n = put(n, 6, 1, 2); n = put(n, 1, 0, 6);
    compute_model(n);
    fv = -1;
    for (int i = 0; i < n; i++) if (exp_a[i][18] && fv < 0) fv = i;
    if (fv < 0) fv = 0;
    c2 = n - 2;
    clr_a[fv] = 1'b1; clr_a[c2] = 1'b1;
    compute_model(n); run_seq(n);
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL set_clear cyc %0d: got %05h want %05h", i, obs_a[i], exp_a[i]); end
    end
    n_cmp++;
    if (obs_a[fv][18] !== 1'b1 || obs_a[fv][1] !== 1'b1) begin
      n_bad++; $display("FAIL set_clear_set_wins: got valid %0b err %0b want 1 1", obs_a[fv][18], obs_a[fv][1]);
    end
    n_cmp++;
    if (obs_a[c2][1] !== 1'b0 || obs_a[c2-1][1] !== 1'b1) begin
      n_bad++; $display("FAIL set_clear_later_clear: got err %0b->%0b want 1->0", obs_a[c2-1][1], obs_a[c2][1]);
    end
  endtask

  task automatic test_midrun_reset();
    int n, fv;
    do_reset();
    n = put(0, 5, 2, 2); n = put(n, 1, 1, 0);
    compute_model(n); run_seq(n);
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL midrun_pre cyc %0d: got %05h want %05h", i, obs_a[i], exp_a[i]); end
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({meas_valid, period, high_time, period_err, timeout} !== 19'd0) begin
      n_bad++; $display("FAIL midrun_in_reset: got %05h want 00000", {meas_valid, period, high_time, period_err, timeout});
    end
    do_reset();
    n = put(0, 6, 1, 2); n = put(n, 1, 0, 6);
    compute_model(n); run_seq(n);
    fv = -1;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL midrun_post cyc %0d: got %05h want %05h", i, obs_a[i], exp_a[i]); end
      if (obs_a[i][18] && fv < 0) fv = i;
    end
    n_cmp++;
    if (fv != 4 + LAT) begin n_bad++; $display("FAIL midrun_first_valid: got cyc %0d want %0d", fv, 4 + LAT); end
  endtask

  task automatic test_random();
    int n, hi, lo, reps;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      n = 0;
      while (n < 400) begin
        hi = $urandom_range(1, 5); lo = $urandom_range(1, 5); reps = $urandom_range(2, 6);
        n = put(n, reps, hi, lo);
      end
      n = put(n, 1, 0, 8);
      for (int i = 0; i < n; i++) clr_a[i] = ($urandom_range(0, 15) == 0);
      compute_model(n); run_seq(n);
      for (int i = 0; i < n; i++) begin
        n_cmp++;
        if (obs_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL random r%0d cyc %0d: got %05h want %05h", round, i, obs_a[i], exp_a[i]); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; clock_mon = 1'b0; clr_flags = 1'b0;
    test_reset();
    test_div3_h1();
    test_div3_h2();
    test_wrong_ratio();
    test_stuck_low();
    test_stuck_high();
    test_set_clear();
    test_midrun_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
